// File: rtl/uart_boot_pkg.sv
// Shared types and byte constants for the UART boot loader.
package uart_boot_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_DATA,
    ST_CSUM,
    ST_ACK
  } boot_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_BITS,
    RX_STOP
  } rx_state_t;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] ACK_OK    = 8'h4B;
  localparam logic [7:0] ACK_ERR   = 8'h45;

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: 2-FF synchroniser, mid-bit sampling, glitch-rejecting start check.
// byte_vld pulses one cycle after the mid-stop-bit sample; frame_err qualifies that pulse.
module uart_rx_core
  import uart_boot_pkg::*;
#(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       byte_vld,
  output logic [7:0] byte_dat,
  output logic       frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

  logic          rx_meta, rx_sync, rx_prev;
  rx_state_t     state, state_nxt;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          tick_half, tick_full;
  logic          done_nxt, ferr_nxt;

  assign tick_half = (cnt == HALF);
  assign tick_full = (cnt == FULL);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RX_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RX_IDLE:  if (rx_prev && !rx_sync) state_nxt = RX_START;
      // a start bit that is high again at half-bit was only a glitch
      RX_START: if (tick_half) state_nxt = rx_sync ? RX_IDLE : RX_BITS;
      RX_BITS:  if (tick_full && bit_idx == 3'd7) state_nxt = RX_STOP;
      RX_STOP:  if (tick_full) state_nxt = RX_IDLE;
      default:  state_nxt = RX_IDLE;
    endcase
  end

  always_comb begin
    done_nxt = (state == RX_STOP) && tick_full;
    ferr_nxt = done_nxt && !rx_sync;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      byte_vld  <= 1'b0;
      byte_dat  <= '0;
      frame_err <= 1'b0;
    end else begin
      if (state == RX_IDLE || state != state_nxt || (state == RX_BITS && tick_full))
        cnt <= '0;
      else
        cnt <= cnt + 1'b1;
      if (state == RX_START)
        bit_idx <= '0;
      else if (state == RX_BITS && tick_full)
        bit_idx <= bit_idx + 1'b1;
      if (state == RX_BITS && tick_full)
        shreg <= {rx_sync, shreg[7:1]};
      byte_vld  <= done_nxt;
      frame_err <= ferr_nxt;
      if (done_nxt) byte_dat <= shreg;
    end
  end

endmodule

// File: rtl/uart_boot_loader.sv
// Receives a framed image over UART, writes it to instruction memory, holds the CPU
// in reset while loading and replies 'K' or 'E'. mem_we follows the 4th byte by one cycle.
module uart_boot_loader
  import uart_boot_pkg::*;
#(
  parameter int  CLOCK_FREQ     = 25000000,
  parameter int  BIT_RATE       = 115200,
  parameter int  MEMORY_SIZE    = 2048,
  parameter int  TIMEOUT_CYCLES = 2500000,
  localparam int WORDS          = MEMORY_SIZE / 4,
  localparam int AW             = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          rx,
  output logic          tx,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic          cpu_reset_o,
  output logic          busy,
  output logic          load_ok,
  output logic          load_err
);

  localparam int CLKS_PER_BIT = CLOCK_FREQ / BIT_RATE;
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0]   MAX_WORDS = 16'(WORDS);

  logic          rx_vld, rx_ferr, byte_ok;
  logic [7:0]    rx_dat;
  boot_state_t   state, state_nxt;
  logic          ack_good, ack_good_nxt;
  logic [7:0]    len_lo;
  logic [15:0]   len_rx;
  logic [AW-1:0] last_idx, word_idx;
  logic [1:0]    byte_idx;
  logic [23:0]   word_buf;
  logic [7:0]    csum;
  logic [TW-1:0] to_cnt;
  logic          in_frame, timeout;
  logic          tx_active, tx_done;
  logic [CW-1:0] tx_cnt;
  logic [3:0]    tx_bit;
  logic [8:0]    tx_shift;
  logic          wr_fire, frame_start, ack_done;

  uart_rx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .byte_vld  (rx_vld),
    .byte_dat  (rx_dat),
    .frame_err (rx_ferr)
  );

  // framing errors never count as activity, so they cannot hold off the timeout
  assign byte_ok  = rx_vld & ~rx_ferr;
  assign len_rx   = {rx_dat, len_lo};
  assign in_frame = (state == ST_LEN_LO) || (state == ST_LEN_HI) ||
                    (state == ST_DATA)   || (state == ST_CSUM);
  assign timeout  = in_frame && !byte_ok && (to_cnt == TO_LAST);
  assign tx_done  = tx_active && (tx_cnt == BIT_LAST) && (tx_bit == 4'd9);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      ack_good <= 1'b0;
    end else begin
      state    <= state_nxt;
      ack_good <= ack_good_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    ack_good_nxt = ack_good;
    case (state)
      ST_IDLE:   if (byte_ok && rx_dat == SYNC_BYTE) state_nxt = ST_LEN_LO;
      ST_LEN_LO: if (byte_ok) state_nxt = ST_LEN_HI;
      ST_LEN_HI: if (byte_ok) begin
        if (len_rx > MAX_WORDS) begin
          state_nxt    = ST_ACK;
          ack_good_nxt = 1'b0;
        end else if (len_rx == 16'd0) begin
          state_nxt = ST_CSUM;
        end else begin
          state_nxt = ST_DATA;
        end
      end
      ST_DATA:   if (byte_ok && byte_idx == 2'd3 && word_idx == last_idx) state_nxt = ST_CSUM;
      ST_CSUM:   if (byte_ok) begin
        state_nxt    = ST_ACK;
        ack_good_nxt = (rx_dat == csum);
      end
      ST_ACK:    if (tx_done) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
    if (timeout) begin
      state_nxt    = ST_ACK;
      ack_good_nxt = 1'b0;
    end
  end

  always_comb begin
    wr_fire     = (state == ST_DATA) && byte_ok && (byte_idx == 2'd3);
    frame_start = (state == ST_IDLE) && byte_ok && (rx_dat == SYNC_BYTE);
    ack_done    = (state == ST_ACK) && tx_done;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_cnt   <= '0;
      len_lo   <= '0;
      last_idx <= '0;
      word_idx <= '0;
      byte_idx <= '0;
      word_buf <= '0;
      csum     <= '0;
    end else begin
      to_cnt <= (!in_frame || byte_ok) ? '0 : to_cnt + 1'b1;
      if (frame_start) begin
        word_idx <= '0;
        byte_idx <= '0;
        csum     <= '0;
      end
      if (state == ST_LEN_LO && byte_ok) len_lo <= rx_dat;
      if (state == ST_LEN_HI && byte_ok) last_idx <= AW'(len_rx - 16'd1);
      if (state == ST_DATA && byte_ok) begin
        csum     <= csum + rx_dat;
        byte_idx <= byte_idx + 1'b1;
        case (byte_idx)
          2'd0:    word_buf[7:0]   <= rx_dat;
          2'd1:    word_buf[15:8]  <= rx_dat;
          2'd2:    word_buf[23:16] <= rx_dat;
          default: word_idx        <= word_idx + 1'b1;
        endcase
      end
    end
  end

  // CPU reset is only released after the 'K' stop bit has left the pin
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      busy        <= 1'b0;
      cpu_reset_o <= 1'b1;
      load_ok     <= 1'b0;
      load_err    <= 1'b0;
    end else begin
      mem_we <= wr_fire;
      if (wr_fire) begin
        mem_addr  <= word_idx;
        mem_wdata <= {rx_dat, word_buf};
      end
      if (frame_start) begin
        busy        <= 1'b1;
        cpu_reset_o <= 1'b1;
        load_ok     <= 1'b0;
        load_err    <= 1'b0;
      end else if (ack_done) begin
        busy <= 1'b0;
        if (ack_good) begin
          cpu_reset_o <= 1'b0;
          load_ok     <= 1'b1;
        end else begin
          load_err <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx        <= 1'b1;
      tx_active <= 1'b0;
      tx_cnt    <= '0;
      tx_bit    <= '0;
      tx_shift  <= '1;
    end else if (!tx_active) begin
      if (state == ST_ACK) begin
        tx        <= 1'b0;
        tx_active <= 1'b1;
        tx_cnt    <= '0;
        tx_bit    <= '0;
        tx_shift  <= {1'b1, ack_good ? ACK_OK : ACK_ERR};
      end
    end else if (tx_cnt == BIT_LAST) begin
      tx_cnt <= '0;
      if (tx_bit == 4'd9) begin
        tx_active <= 1'b0;
      end else begin
        tx       <= tx_shift[0];
        tx_shift <= {1'b1, tx_shift[8:1]};
        tx_bit   <= tx_bit + 1'b1;
      end
    end else begin
      tx_cnt <= tx_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Directed bench: dut_a (112 clk/bit) covers loads, errors, glitches and reset;
// dut_b (16 clk/bit, 1000-cycle timeout) covers the inter-byte timeout.
module tb_uart_boot_loader;

  localparam int CPB_A = 112;
  localparam int CPB_B = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, rx_a, rx_b;
  logic        tx_a, mem_we_a, cpu_reset_a, busy_a, load_ok_a, load_err_a;
  logic [8:0]  mem_addr_a;
  logic [31:0] mem_wdata_a;
  logic        tx_b, mem_we_b, cpu_reset_b, busy_b, load_ok_b, load_err_b;
  logic [8:0]  mem_addr_b;
  logic [31:0] mem_wdata_b;

  uart_boot_loader #(
    .CLOCK_FREQ(11200000), .BIT_RATE(100000), .MEMORY_SIZE(2048), .TIMEOUT_CYCLES(5000)
  ) dut_a (
    .clk(clk), .reset(reset), .rx(rx_a), .tx(tx_a), .mem_we(mem_we_a),
    .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a), .cpu_reset_o(cpu_reset_a),
    .busy(busy_a), .load_ok(load_ok_a), .load_err(load_err_a)
  );

  uart_boot_loader #(
    .CLOCK_FREQ(1600000), .BIT_RATE(100000), .MEMORY_SIZE(2048), .TIMEOUT_CYCLES(1000)
  ) dut_b (
    .clk(clk), .reset(reset), .rx(rx_b), .tx(tx_b), .mem_we(mem_we_b),
    .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .cpu_reset_o(cpu_reset_b),
    .busy(busy_b), .load_ok(load_ok_b), .load_err(load_err_b)
  );

  int          n_assert = 0;
  int          n_fail = 0;
  int          wr_b = 0;
  logic [8:0]  wa_q[$];
  logic [31:0] wd_q[$];
  logic [7:0]  ack_a_q[$];
  logic [7:0]  ack_b_q[$];
  logic [7:0]  fr[$];
  logic [7:0]  ack;
  logic        rst_at_ack;

  always @(negedge clk) begin
    if (mem_we_a) begin
      wa_q.push_back(mem_addr_a);
      wd_q.push_back(mem_wdata_a);
    end
    if (mem_we_b) wr_b = wr_b + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tx_monitor(input bit which);
    int cpb;
    logic [7:0] b;
    cpb = which ? CPB_B : CPB_A;
    forever begin
      @(negedge clk);
      if ((which ? tx_b : tx_a) == 1'b0) begin
        repeat (cpb / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (cpb) @(negedge clk);
          b[i] = which ? tx_b : tx_a;
        end
        repeat (cpb) @(negedge clk);
        if (which) ack_b_q.push_back(b);
        else       ack_a_q.push_back(b);
      end
    end
  endtask

  initial tx_monitor(1'b0);
  initial tx_monitor(1'b1);

  task automatic set_rx(input bit which, input logic v);
    if (which) rx_b = v;
    else       rx_a = v;
  endtask

  task automatic send_byte(input bit which, input logic [7:0] b);
    int cpb;
    cpb = which ? CPB_B : CPB_A;
    set_rx(which, 1'b0);
    repeat (cpb) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      set_rx(which, b[i]);
      repeat (cpb) @(negedge clk);
    end
    set_rx(which, 1'b1);
    repeat (cpb) @(negedge clk);
  endtask

  task automatic send_frame(input bit which);
    foreach (fr[i]) send_byte(which, fr[i]);
  endtask

  task automatic wait_ack(input bit which, input int budget, output logic [7:0] b,
                          output logic rst_seen);
    b = 'x;
    rst_seen = 'x;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (which && ack_b_q.size() > 0) begin
        b = ack_b_q.pop_front();
        rst_seen = cpu_reset_b;
        break;
      end
      if (!which && ack_a_q.size() > 0) begin
        b = ack_a_q.pop_front();
        rst_seen = cpu_reset_a;
        break;
      end
    end
  endtask

  task automatic check_reset_a(input string stage);
    check({stage, "_tx"}, tx_a, 1'b1);
    check({stage, "_cpu_reset"}, cpu_reset_a, 1'b1);
    check({stage, "_mem_we"}, mem_we_a, 1'b0);
    check({stage, "_mem_addr"}, mem_addr_a, 9'd0);
    check({stage, "_mem_wdata"}, mem_wdata_a, 32'd0);
    check({stage, "_busy"}, busy_a, 1'b0);
    check({stage, "_load_ok"}, load_ok_a, 1'b0);
    check({stage, "_load_err"}, load_err_a, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    rx_a  = 1'b1;
    rx_b  = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_a("por");
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // good two-word load; checksum 0x13+0xEF+0xBE+0xAD+0xDE = 0x34B -> 0x4B
    wa_q.delete(); wd_q.delete();
    fr = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h4B};
    send_byte(1'b0, 8'hA5);
    repeat (2) @(negedge clk);
    check("t1_busy_mid", busy_a, 1'b1);
    check("t1_cpu_reset_mid", cpu_reset_a, 1'b1);
    send_frame(1'b0);
    wait_ack(1'b0, 20 * CPB_A, ack, rst_at_ack);
    check("t1_ack", ack, 8'h4B);
    check("t1_cpu_reset_during_ack", rst_at_ack, 1'b1);
    repeat (CPB_A) @(negedge clk);
    check("t1_wr_count", wa_q.size(), 2);
    if (wa_q.size() == 2) begin
      check("t1_addr0", wa_q[0], 9'd0);
      check("t1_data0", wd_q[0], 32'h0000_0013);
      check("t1_addr1", wa_q[1], 9'd1);
      check("t1_data1", wd_q[1], 32'hDEAD_BEEF);
    end
    check("t1_cpu_reset", cpu_reset_a, 1'b0);
    check("t1_load_ok", load_ok_a, 1'b1);
    check("t1_load_err", load_err_a, 1'b0);
    check("t1_busy", busy_a, 1'b0);

    // same image, bad checksum
    wa_q.delete(); wd_q.delete();
    fr = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h00};
    send_frame(1'b0);
    wait_ack(1'b0, 20 * CPB_A, ack, rst_at_ack);
    check("t2_ack", ack, 8'h45);
    repeat (CPB_A) @(negedge clk);
    check("t2_wr_count", wa_q.size(), 2);
    if (wa_q.size() == 2) check("t2_data1", wd_q[1], 32'hDEAD_BEEF);
    check("t2_load_err", load_err_a, 1'b1);
    check("t2_load_ok", load_ok_a, 1'b0);
    check("t2_cpu_reset", cpu_reset_a, 1'b1);

    // N = 513 exceeds 512 words
    wa_q.delete(); wd_q.delete();
    fr = '{8'hA5, 8'h01, 8'h02};
    send_frame(1'b0);
    wait_ack(1'b0, 20 * CPB_A, ack, rst_at_ack);
    check("t3_ack", ack, 8'h45);
    repeat (CPB_A) @(negedge clk);
    check("t3_wr_count", wa_q.size(), 0);
    check("t3_busy", busy_a, 1'b0);
    check("t3_load_err", load_err_a, 1'b1);

    // garbage and a 50-cycle glitch, then an empty frame
    send_byte(1'b0, 8'h00);
    send_byte(1'b0, 8'hFF);
    rx_a = 1'b0;
    repeat (50) @(negedge clk);
    rx_a = 1'b1;
    repeat (3 * CPB_A) @(negedge clk);
    check("t4_garbage_busy", busy_a, 1'b0);
    check("t4_garbage_no_ack", ack_a_q.size(), 0);
    fr = '{8'hA5, 8'h00, 8'h00, 8'h00};
    send_frame(1'b0);
    wait_ack(1'b0, 20 * CPB_A, ack, rst_at_ack);
    check("t4_ack", ack, 8'h4B);
    repeat (CPB_A) @(negedge clk);
    check("t4_cpu_reset", cpu_reset_a, 1'b0);
    check("t4_load_ok", load_ok_a, 1'b1);
    check("t4_wr_count", wa_q.size(), 0);

    // reset in the middle of a word, then reload
    fr = '{8'hA5, 8'h01, 8'h00, 8'h78, 8'h56};
    send_frame(1'b0);
    @(negedge clk);
    reset = 1'b1;
    #2;
    check_reset_a("t5");
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    wa_q.delete(); wd_q.delete();
    fr = '{8'hA5, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h14};
    send_frame(1'b0);
    wait_ack(1'b0, 20 * CPB_A, ack, rst_at_ack);
    check("t5_ack", ack, 8'h4B);
    repeat (CPB_A) @(negedge clk);
    check("t5_wr_count", wa_q.size(), 1);
    if (wa_q.size() == 1) begin
      check("t5_addr0", wa_q[0], 9'd0);
      check("t5_data0", wd_q[0], 32'h1234_5678);
    end
    check("t5_load_ok", load_ok_a, 1'b1);
    check("t5_cpu_reset", cpu_reset_a, 1'b0);

    // stall after two payload bytes on the short-timeout instance
    wr_b = 0;
    fr = '{8'hA5, 8'h01, 8'h00, 8'hAA, 8'hBB};
    send_frame(1'b1);
    repeat (900) @(negedge clk);
    check("t6_no_early_ack_tx", tx_b, 1'b1);
    check("t6_busy_before", busy_b, 1'b1);
    wait_ack(1'b1, 600, ack, rst_at_ack);
    check("t6_ack", ack, 8'h45);
    repeat (CPB_B) @(negedge clk);
    check("t6_busy_after", busy_b, 1'b0);
    check("t6_load_err", load_err_b, 1'b1);
    check("t6_load_ok", load_ok_b, 1'b0);
    check("t6_cpu_reset", cpu_reset_b, 1'b1);
    check("t6_wr_count", wr_b, 0);
    check("t6_mem_addr", mem_addr_b, 9'd0);
    check("t6_mem_wdata", mem_wdata_b, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
